// File: rtl/serial_addsub.sv
// Digit-serial add/subtract: WIDTH-bit operands are processed DIGIT bits per cycle
// over N = WIDTH/DIGIT cycles, with a valid/ready handshake on both sides.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_addsub: WIDTH must be >= 2 and an exact multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic [WIDTH-1:0]       r_s;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_carry;
    logic                   r_sub;
    logic                   r_a_msb;
    logic                   r_b_msb;
    logic                   r_cout;
    logic                   r_ovf;
    logic                   r_zero;

    logic [DIGIT:0]         w_c;
    logic [DIGIT-1:0]       w_digit;
    logic [WIDTH+DIGIT-1:0] w_s_cat;
    logic [WIDTH-1:0]       w_s_shift;
    logic                   w_last;
    logic                   w_sign_cond;

    // Subtraction runs as A + ~B + ~Cin; B and the borrow are inverted once at accept.
    assign w_c[0] = r_carry;
    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
            assign w_digit[gi] = r_a[gi] ^ r_b[gi] ^ w_c[gi];
            assign w_c[gi+1]   = (r_a[gi] & r_b[gi]) | (w_c[gi] & (r_a[gi] ^ r_b[gi]));
        end
    endgenerate

    // New digit enters at the MSB end; after N shifts the first digit sits at bit 0.
    assign w_s_cat     = {w_digit, r_s};
    assign w_s_shift   = w_s_cat[WIDTH+DIGIT-1:DIGIT];
    assign w_last      = (r_cnt == CNT_W'(N - 1));
    assign w_sign_cond = r_sub ? (r_a_msb != r_b_msb) : (r_a_msb == r_b_msb);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= A;
                        r_b     <= B ^ {WIDTH{sub}};
                        r_carry <= Cin ^ sub;
                        r_sub   <= sub;
                        r_a_msb <= A[WIDTH-1];
                        r_b_msb <= B[WIDTH-1];
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_c[DIGIT];
                    r_s     <= w_s_shift;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_cout <= w_c[DIGIT] ^ r_sub;
                        r_ovf  <= w_sign_cond && (w_s_shift[WIDTH-1] != r_a_msb);
                        r_zero <= (w_s_shift == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign S         = r_s;
    assign Cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_serial_addsub.sv
// Drives four serial_addsub instances (DIGIT = 1, 2, 4, 8; WIDTH = 8) in lockstep
// from a directed vector table, a reset-abort sequence and a modelled random run.
module tb_serial_addsub;

    localparam int NI = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            out_ready;
    logic [7:0]      A;
    logic [7:0]      B;
    logic            Cin;
    logic            sub;
    logic [NI-1:0]   ir;
    logic [NI-1:0]   ov;
    logic [NI-1:0]   co;
    logic [NI-1:0]   of;
    logic [NI-1:0]   zr;
    logic [7:0]      s_o [NI];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        serial_addsub #(.WIDTH(8), .DIGIT(1 << gi)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (ir[gi]),
            .A         (A),
            .B         (B),
            .Cin       (Cin),
            .sub       (sub),
            .out_valid (ov[gi]),
            .out_ready (out_ready),
            .S         (s_o[gi]),
            .Cout      (co[gi]),
            .ovf       (of[gi]),
            .zero      (zr[gi])
        );
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sb;
        logic [7:0] s;
        logic       cout;
        logic       ovf;
        logic       zero;
        int         stall;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s digit=%0d got=%0h want=%0h", nm, d, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t model(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                   input logic sb, input int stall);
        vec_t v;
        logic [8:0] r;
        v.a = a; v.b = b; v.cin = cin; v.sb = sb; v.stall = stall;
        if (!sb) begin
            r      = {1'b0, a} + {1'b0, b} + {8'b0, cin};
            v.s    = r[7:0];
            v.cout = r[8];
            v.ovf  = (a[7] == b[7]) && (v.s[7] != a[7]);
        end else begin
            r      = {1'b0, a} - {1'b0, b} - {8'b0, cin};
            v.s    = r[7:0];
            v.cout = ({1'b0, a} < ({1'b0, b} + {8'b0, cin}));
            v.ovf  = (a[7] != b[7]) && (v.s[7] != a[7]);
        end
        v.zero = (v.s == 8'h00);
        return v;
    endfunction

    task automatic check_result(input vec_t v, input string tag);
        for (int i = 0; i < NI; i++) begin
            chk({tag, " S"},         1 << i, 32'(s_o[i]), 32'(v.s));
            chk({tag, " Cout"},      1 << i, 32'(co[i]),  32'(v.cout));
            chk({tag, " ovf"},       1 << i, 32'(of[i]),  32'(v.ovf));
            chk({tag, " zero"},      1 << i, 32'(zr[i]),  32'(v.zero));
            chk({tag, " out_valid"}, 1 << i, 32'(ov[i]),  32'd1);
            chk({tag, " in_ready"},  1 << i, 32'(ir[i]),  32'd0);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int rise [NI];
        for (int i = 0; i < NI; i++) begin
            chk({tag, " idle in_ready"}, 1 << i, 32'(ir[i]), 32'd1);
            rise[i] = -1;
        end
        A = v.a; B = v.b; Cin = v.cin; sub = v.sb; in_valid = 1'b1;
        tick();
        // Scrambled operands and a stray in_valid while busy must not disturb the result.
        A = ~v.a; B = v.b + 8'h5A; Cin = ~v.cin; sub = ~v.sb;
        for (int k = 1; k <= 10; k++) begin
            tick();
            for (int i = 0; i < NI; i++)
                if (rise[i] < 0 && ov[i]) rise[i] = k;
            if (rise[0] >= 0 && rise[1] >= 0 && rise[2] >= 0 && rise[3] >= 0) break;
        end
        in_valid = 1'b0;
        for (int i = 0; i < NI; i++)
            chk({tag, " latency"}, 1 << i, 32'(rise[i]), 32'(8 >> i));
        check_result(v, tag);
        for (int s = 0; s < v.stall; s++) begin
            tick();
            check_result(v, {tag, " stall"});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk({tag, " drained out_valid"}, 1 << i, 32'(ov[i]), 32'd0);
            chk({tag, " drained in_ready"},  1 << i, 32'(ir[i]), 32'd1);
        end
        $display("%s: %s a=%h b=%h cin=%0d -> S=%h Cout=%0d ovf=%0d zero=%0d stall=%0d",
                 tag, v.sb ? "sub" : "add", v.a, v.b, v.cin, s_o[0], co[0], of[0], zr[0], v.stall);
    endtask

    initial begin
        vec_t rv;
        logic seen;

        //            a      b     cin sb   S     Cout ovf zero stall
        tbl[0]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 0};
        tbl[1]  = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1};
        tbl[2]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 0};
        tbl[3]  = '{8'h05, 8'h04, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 2};
        tbl[4]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5};
        tbl[5]  = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 0};
        tbl[6]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 0};
        tbl[7]  = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1};
        tbl[8]  = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0};
        tbl[9]  = '{8'h3C, 8'h0F, 1'b1, 1'b1, 8'h2C, 1'b0, 1'b0, 1'b0, 0};
        tbl[10] = '{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 0};
        tbl[11] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 0};
        tbl[12] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 3};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = 8'h00; B = 8'h00; Cin = 1'b0; sub = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < NI; i++) begin
            chk("reset out_valid", 1 << i, 32'(ov[i]),  32'd0);
            chk("reset in_ready",  1 << i, 32'(ir[i]),  32'd1);
            chk("reset S",         1 << i, 32'(s_o[i]), 32'd0);
            chk("reset Cout",      1 << i, 32'(co[i]),  32'd0);
            chk("reset ovf",       1 << i, 32'(of[i]),  32'd0);
            chk("reset zero",      1 << i, 32'(zr[i]),  32'd0);
        end
        rst = 1'b0;
        tick();

        for (int t = 0; t < 13; t++)
            run_op(tbl[t], $sformatf("vec%0d", t));

        // Abort mid-operation: reset lands on the third RUN edge while operands change.
        A = 8'h7F; B = 8'h01; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; A = 8'h12; B = 8'h34; Cin = 1'b1; sub = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk("abort out_valid", 1 << i, 32'(ov[i]),  32'd0);
            chk("abort in_ready",  1 << i, 32'(ir[i]),  32'd1);
            chk("abort S",         1 << i, 32'(s_o[i]), 32'd0);
            chk("abort Cout",      1 << i, 32'(co[i]),  32'd0);
            chk("abort ovf",       1 << i, 32'(of[i]),  32'd0);
        end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            seen = seen | (|ov);
        end
        chk("abort no out_valid pulse", 0, 32'(seen), 32'd0);
        $display("abort: reset on RUN cycle 3 -> in_ready=%b out_valid=%b", ir, ov);
        run_op(tbl[0], "post_abort");

        for (int r = 0; r < 200; r++) begin
            rv = model(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
            run_op(rv, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 1: bits processed per cycle; SHALL divide WIDTH exactly (elaboration error otherwise).
REQ-003 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port in_valid  input  1: operand bundle valid.
REQ-006 Port in_ready  output  1: block can accept a new operation.
REQ-007 Port A  input  WIDTH: minuend/augend.
REQ-008 Port B  input  WIDTH: subtrahend/addend.
REQ-009 Port Cin  input  1: carry-in (add) or borrow-in (sub).
REQ-010 Port sub  input  1: mode; 0 = add, 1 = subtract.
REQ-011 Port out_valid  output  1: result valid.
REQ-012 Port out_ready  input  1: consumer accepts result.
REQ-013 Port S  output  WIDTH: result.
REQ-014 Port Cout  output  1: carry-out (add) or borrow-out (sub).
REQ-015 Port ovf  output  1: two's-complement signed overflow.
REQ-016 Port zero  output  1: S equals all zeros.

Function
REQ-017 FSM SHALL have states IDLE, RUN, DONE; N = WIDTH/DIGIT.
REQ-018 IDLE: in_ready=1, out_valid=0; on in_valid=1, latch A, B, Cin, sub, clear step counter, go to RUN.
REQ-019 RUN: each cycle process DIGIT LSBs of the shifted operands with the running carry/borrow, shift result digit into S from the MSB end, increment counter; after the N-th RUN cycle go to DONE.
REQ-020 Add mode SHALL yield {Cout,S} = A + B + Cin, modulo 2^(WIDTH+1).
REQ-021 Sub mode SHALL yield S = (A - B - Cin) mod 2^WIDTH, Cout = 1 iff A < B + Cin (unsigned borrow).
REQ-022 ovf: add = (A[MSB]==B[MSB]) && (S[MSB]!=A[MSB]); sub = (A[MSB]!=B[MSB]) && (S[MSB]!=A[MSB]).
REQ-023 zero SHALL be 1 iff S == 0 when out_valid=1.
REQ-024 Latency: out_valid SHALL rise exactly N cycles after the accepting edge; accepting edge to result edge is N+1 edges inclusive.
REQ-025 DONE: out_valid=1, S/Cout/ovf/zero stable; on out_ready=1 go to IDLE; hold indefinitely while out_ready=0.
REQ-026 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored and no operand latched.
REQ-027 Inputs A, B, Cin, sub SHALL be sampled only on the accepting edge; changes afterwards SHALL not affect the result.
REQ-028 Throughput: at most one operation per N+2 cycles (accept, N RUN, DONE handshake).
REQ-029 Outputs S, Cout, ovf, zero SHALL be driven from registers only; no combinational path from inputs to outputs.
REQ-030 out_ready while not in DONE SHALL have no effect.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, counter=0, S=0, Cout=0, ovf=0, zero=0, out_valid=0; in_ready=1 from the following cycle.
REQ-032 rst SHALL take priority over in_valid and out_ready in the same cycle; an operation in RUN or DONE is discarded with no out_valid pulse.

Verification (WIDTH=8 unless noted)
REQ-033 DIGIT=1, add A=0x7F B=0x01 Cin=0 -> out_valid 8 cycles after accept, S=0x80, Cout=0, ovf=1, zero=0.
REQ-034 DIGIT=1, sub A=0x00 B=0x01 Cin=0 -> S=0xFF, Cout=1, ovf=0; sub A=0x80 B=0x01 -> S=0x7F, Cout=0, ovf=1.
REQ-035 DIGIT=2, sub A=0x05 B=0x04 Cin=1 -> S=0x00, zero=1, Cout=0, out_valid 4 cycles after accept.
REQ-036 DIGIT=4, add A=0xFF B=0x01 Cin=0 -> S=0x00, Cout=1, zero=1, out_valid 2 cycles after accept; out_ready held 0 for 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-037 Assert rst on RUN cycle 3, operands changed during RUN -> next cycle out_valid=0, in_ready=1, S=0; following operation returns correct result unaffected.
REQ-038 Random: 10k operations, random mode/operands/Cin/out_ready stalls, DIGIT in {1,2,4,8} -> every result matches reference arithmetic model per REQ-020..REQ-023.
